store_queue_fwd: RTL and testbench

Parametrised store queue for the LSU. It holds dispatched stores in program order and accepts address and size from the AGU. Stores retire to the D-cache through a valid/ready port once the ROB commits them. Loads get byte-granular store-to-load forwarding with age-correct priority, and the whole uncommitted region can be flushed on a mispredict.

---
 rtl/store_queue_fwd.sv | 218 +++++++++++++++++++++
 tb/tb_store_queue_fwd.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue_fwd.sv
// Store queue for the LSU.
// Holds dispatched stores in program order and takes address/size from the AGU.
// Retires committed stores to the D-cache through a valid/ready port.
// Gives loads byte-granular, age-correct store-to-load forwarding.
// A mispredict flush squashes every uncommitted entry.
module store_queue_fwd #(
    parameter int SQ_ENTRIES = 8,
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 32,
    parameter int IDX_W      = $clog2(SQ_ENTRIES),
    parameter int PTR_W      = IDX_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              disp_vld_i,
    input  logic [XLEN-1:0]   disp_data_i,
    output logic [PTR_W-1:0]  alloc_ptr_o,
    output logic              full_o,
    input  logic              exec_vld_i,
    input  logic [IDX_W-1:0]  exec_idx_i,
    input  logic [ADDR_W-1:0] exec_addr_i,
    input  logic [1:0]        exec_size_i,
    input  logic              cmit_vld_i,
    input  logic [IDX_W-1:0]  cmit_idx_i,
    input  logic              flush_i,
    output logic              issue_vld_o,
    input  logic              issue_rdy_i,
    output logic [ADDR_W-1:0] issue_addr_o,
    output logic [XLEN-1:0]   issue_data_o,
    output logic [1:0]        issue_size_o,
    input  logic              ld_vld_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [1:0]        ld_size_i,
    input  logic [PTR_W-1:0]  ld_marker_i,
    output logic              ld_hit_o,
    output logic              ld_stall_o,
    output logic [XLEN-1:0]   ld_data_o
);

    // The pointer wrap-bit scheme only works for power-of-two depths.
    // The byte lanes are hard-wired for a 32-bit data path.
    if ((SQ_ENTRIES < 2) || ((SQ_ENTRIES & (SQ_ENTRIES - 1)) != 0)) begin : g_bad_entries
        $error("store_queue_fwd: SQ_ENTRIES must be a power of 2");
    end
    if (XLEN != 32) begin : g_bad_xlen
        $error("store_queue_fwd: XLEN must be 32");
    end

    logic [SQ_ENTRIES-1:0] ent_valid;
    logic [SQ_ENTRIES-1:0] ent_addr_valid;
    logic [SQ_ENTRIES-1:0] ent_committed;
    logic [ADDR_W-1:0]     ent_addr [SQ_ENTRIES];
    logic [1:0]            ent_size [SQ_ENTRIES];
    logic [XLEN-1:0]       ent_data [SQ_ENTRIES];

    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [IDX_W-1:0]      head_idx;
    logic [IDX_W-1:0]      tail_idx;

    logic                  deq;
    logic                  disp_acc;
    logic                  exec_aligned;
    logic [SQ_ENTRIES-1:0] cmit_set;
    logic [SQ_ENTRIES-1:0] commit_next;
    logic [PTR_W-1:0]      head_next;
    logic [PTR_W-1:0]      keep_cnt;

    logic [3:0]            ld_mask;
    logic [3:0]            st_mask;
    logic [3:0]            found_mask;
    logic [PTR_W-1:0]      older_cnt;
    logic [IDX_W-1:0]      scan_idx;
    logic [IDX_W-1:0]      found_idx;
    logic                  found;
    logic                  found_unknown;
    logic [1:0]            lane_shift;
    logic [XLEN-1:0]       shifted;

    // Bytes touched by an access of the given size at the given word offset.
    function automatic logic [3:0] byte_mask(input logic [1:0] off, input logic [1:0] size);
        case (size)
            2'd0:    byte_mask = 4'b0001 << off;
            2'd1:    byte_mask = 4'b0011 << off;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

    assign head_idx     = head[IDX_W-1:0];
    assign tail_idx     = tail[IDX_W-1:0];
    assign full_o       = (head[PTR_W-1] != tail[PTR_W-1]) && (head_idx == tail_idx);
    assign alloc_ptr_o  = tail;
    assign issue_vld_o  = ent_valid[head_idx] & ent_addr_valid[head_idx] & ent_committed[head_idx];
    assign issue_addr_o = ent_addr[head_idx];
    assign issue_data_o = ent_data[head_idx];
    assign issue_size_o = ent_size[head_idx];
    assign deq          = issue_vld_o & issue_rdy_i;
    assign disp_acc     = disp_vld_i & ~full_o & ~flush_i;
    assign exec_aligned = (exec_size_i == 2'd0)
                       || (exec_size_i == 2'd1 && !exec_addr_i[0])
                       || (exec_size_i == 2'd2 && exec_addr_i[1:0] == 2'b00);

    // Apply the same-cycle commit before the flush.
    // Then count the committed entries that survive the dequeue, which sets the post-flush tail.
    always_comb begin
        cmit_set = '0;
        if (cmit_vld_i) cmit_set[cmit_idx_i] = 1'b1;
        commit_next = ent_committed | cmit_set;
        head_next   = head + PTR_W'(deq);
        keep_cnt    = '0;
        for (int i = 0; i < SQ_ENTRIES; i++) begin
            if (ent_valid[i] && commit_next[i] && !(deq && head_idx == IDX_W'(i)))
                keep_cnt = keep_cnt + PTR_W'(1);
        end
    end

    // Pointer and entry-state update: dispatch, exec, commit, dequeue and flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head           <= '0;
            tail           <= '0;
            ent_valid      <= '0;
            ent_addr_valid <= '0;
            ent_committed  <= '0;
            for (int i = 0; i < SQ_ENTRIES; i++) begin
                ent_addr[i] <= '0;
                ent_size[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            head <= head_next;
            if (flush_i)
                tail <= head_next + keep_cnt;
            else if (disp_acc)
                tail <= tail + PTR_W'(1);
            for (int i = 0; i < SQ_ENTRIES; i++) begin
                if (cmit_set[i])
                    ent_committed[i] <= 1'b1;
                if (exec_vld_i && exec_idx_i == IDX_W'(i) && !(flush_i && !commit_next[i])) begin
                    ent_addr_valid[i] <= 1'b1;
                    ent_addr[i]       <= exec_addr_i;
                    ent_size[i]       <= exec_size_i;
                end
                if (disp_acc && tail_idx == IDX_W'(i)) begin
                    ent_valid[i]      <= 1'b1;
                    ent_addr_valid[i] <= 1'b0;
                    ent_committed[i]  <= 1'b0;
                    ent_data[i]       <= disp_data_i;
                end
                if (deq && head_idx == IDX_W'(i)) begin
                    ent_valid[i]      <= 1'b0;
                    ent_addr_valid[i] <= 1'b0;
                    ent_committed[i]  <= 1'b0;
                end
                if (flush_i && !commit_next[i]) begin
                    ent_valid[i]      <= 1'b0;
                    ent_addr_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Forwarding scan runs oldest to youngest, so the youngest deciding store wins.
    // A marker that head has already passed leaves no older stores.
    always_comb begin
        ld_mask       = byte_mask(ld_addr_i[1:0], ld_size_i);
        older_cnt     = ld_marker_i - head;
        if (older_cnt > PTR_W'(SQ_ENTRIES)) older_cnt = '0;
        found         = 1'b0;
        found_unknown = 1'b0;
        found_idx     = '0;
        scan_idx      = '0;
        st_mask       = '0;
        for (int d = 0; d < SQ_ENTRIES; d++) begin
            scan_idx = head_idx + IDX_W'(d);
            st_mask  = byte_mask(ent_addr[scan_idx][1:0], ent_size[scan_idx]);
            if (PTR_W'(d) < older_cnt && ent_valid[scan_idx]) begin
                if (!ent_addr_valid[scan_idx]) begin
                    found         = 1'b1;
                    found_unknown = 1'b1;
                    found_idx     = scan_idx;
                end else if (ent_addr[scan_idx][ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2]
                             && (st_mask & ld_mask) != 4'b0000) begin
                    found         = 1'b1;
                    found_unknown = 1'b0;
                    found_idx     = scan_idx;
                end
            end
        end

        found_mask = byte_mask(ent_addr[found_idx][1:0], ent_size[found_idx]);
        lane_shift = ld_addr_i[1:0] - ent_addr[found_idx][1:0];
        shifted    = ent_data[found_idx] >> {lane_shift, 3'b000};
        ld_hit_o   = 1'b0;
        ld_stall_o = 1'b0;
        ld_data_o  = '0;
        if (ld_vld_i && found) begin
            if (found_unknown) begin
                ld_stall_o = 1'b1;
            end else if ((found_mask & ld_mask) == ld_mask) begin
                ld_hit_o = 1'b1;
                case (ld_size_i)
                    2'd0:    ld_data_o = shifted & XLEN'(32'h0000_00FF);
                    2'd1:    ld_data_o = shifted & XLEN'(32'h0000_FFFF);
                    default: ld_data_o = shifted;
                endcase
            end else begin
                ld_stall_o = 1'b1;
            end
        end
    end

    // AGU results must be naturally aligned.
    always @(posedge clk_i) begin
        if (!rst_i && exec_vld_i) assert (exec_aligned);
    end

endmodule

// File: tb/tb_store_queue_fwd.sv
// Self-checking bench for store_queue_fwd.
// Forwarding cases are table driven, and retired stores are checked through a scoreboard queue.
module tb_store_queue_fwd;

    logic        clk;
    logic        rst;
    logic        disp_vld;
    logic [31:0] disp_data;
    logic [3:0]  alloc_ptr;
    logic        full;
    logic        exec_vld;
    logic [2:0]  exec_idx;
    logic [31:0] exec_addr;
    logic [1:0]  exec_size;
    logic        cmit_vld;
    logic [2:0]  cmit_idx;
    logic        flush;
    logic        issue_vld;
    logic        issue_rdy;
    logic [31:0] issue_addr;
    logic [31:0] issue_data;
    logic [1:0]  issue_size;
    logic        ld_vld;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic [3:0]  ld_marker;
    logic        ld_hit;
    logic        ld_stall;
    logic [31:0] ld_data;

    int total_checks = 0;
    int pass_checks  = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } sb_entry_t;

    typedef struct {
        logic        vld;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  marker;
        logic        hit;
        logic        stall;
        logic [31:0] data;
    } fwd_vec_t;

    sb_entry_t sb[$];
    sb_entry_t mon_exp;
    fwd_vec_t  fwd_table[15];

    store_queue_fwd dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .disp_vld_i   (disp_vld),
        .disp_data_i  (disp_data),
        .alloc_ptr_o  (alloc_ptr),
        .full_o       (full),
        .exec_vld_i   (exec_vld),
        .exec_idx_i   (exec_idx),
        .exec_addr_i  (exec_addr),
        .exec_size_i  (exec_size),
        .cmit_vld_i   (cmit_vld),
        .cmit_idx_i   (cmit_idx),
        .flush_i      (flush),
        .issue_vld_o  (issue_vld),
        .issue_rdy_i  (issue_rdy),
        .issue_addr_o (issue_addr),
        .issue_data_o (issue_data),
        .issue_size_o (issue_size),
        .ld_vld_i     (ld_vld),
        .ld_addr_i    (ld_addr),
        .ld_size_i    (ld_size),
        .ld_marker_i  (ld_marker),
        .ld_hit_o     (ld_hit),
        .ld_stall_o   (ld_stall),
        .ld_data_o    (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends even if a handshake never arrives.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected) pass_checks++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic clear_pulses();
        disp_vld = 1'b0;
        exec_vld = 1'b0;
        cmit_vld = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        clear_pulses();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        clear_pulses();
        issue_rdy = 1'b0;
        ld_vld    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic dispatch(input logic [31:0] data);
        disp_vld  = 1'b1;
        disp_data = data;
        applyStimulus();
    endtask

    task automatic exec_store(input logic [2:0] idx, input logic [31:0] addr, input logic [1:0] size);
        exec_vld  = 1'b1;
        exec_idx  = idx;
        exec_addr = addr;
        exec_size = size;
        applyStimulus();
    endtask

    task automatic commit_store(input logic [2:0] idx, input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] size);
        cmit_vld = 1'b1;
        cmit_idx = idx;
        sb.push_back('{addr, data, size});
        applyStimulus();
    endtask

    task automatic check_load(input string name, input logic vld, input logic [31:0] addr, input logic [1:0] size,
                              input logic [3:0] marker, input logic hit, input logic stall, input logic [31:0] data);
        ld_vld    = vld;
        ld_addr   = addr;
        ld_size   = size;
        ld_marker = marker;
        #1;
        checkOutput({name, "_hit"}, 32'(ld_hit), 32'(hit));
        checkOutput({name, "_stall"}, 32'(ld_stall), 32'(stall));
        checkOutput({name, "_data"}, ld_data, data);
        ld_vld = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        issue_rdy = 1'b1;
        while (sb.size() != 0 && n < 64) begin
            @(posedge clk);
            n++;
        end
        #1;
        issue_rdy = 1'b0;
        checkOutput(name, 32'(sb.size()), 32'd0);
        #1;
    endtask

    // Each accepted issue is popped from the expected queue and compared field by field.
    always @(negedge clk) begin
        if (!rst && issue_vld && issue_rdy) begin
            if (sb.size() == 0) begin
                total_checks++;
                $display("[TB] FAIL unexpected_issue: got addr 0x%0h, expected no issue", issue_addr);
            end else begin
                mon_exp = sb.pop_front();
                checkOutput("issue_addr", issue_addr, mon_exp.addr);
                checkOutput("issue_data", issue_data, mon_exp.data);
                checkOutput("issue_size", 32'(issue_size), 32'(mon_exp.size));
            end
        end
    end

    initial begin
        fwd_table[0]  = '{1'b1, 32'h202, 2'd0, 4'd2, 1'b1, 1'b0, 32'h22};
        fwd_table[1]  = '{1'b1, 32'h202, 2'd0, 4'd1, 1'b1, 1'b0, 32'h11};
        fwd_table[2]  = '{1'b1, 32'h200, 2'd2, 4'd2, 1'b1, 1'b0, 32'h22222222};
        fwd_table[3]  = '{1'b1, 32'h200, 2'd1, 4'd2, 1'b1, 1'b0, 32'h2222};
        fwd_table[4]  = '{1'b1, 32'h300, 2'd2, 4'd3, 1'b0, 1'b1, 32'h0};
        fwd_table[5]  = '{1'b1, 32'h301, 2'd0, 4'd3, 1'b1, 1'b0, 32'h5A};
        fwd_table[6]  = '{1'b1, 32'h300, 2'd0, 4'd3, 1'b0, 1'b0, 32'h0};
        fwd_table[7]  = '{1'b1, 32'h600, 2'd2, 4'd5, 1'b0, 1'b1, 32'h0};
        fwd_table[8]  = '{1'b1, 32'h403, 2'd0, 4'd6, 1'b1, 1'b0, 32'hBE};
        fwd_table[9]  = '{1'b1, 32'h402, 2'd1, 4'd6, 1'b1, 1'b0, 32'hBEEF};
        fwd_table[10] = '{1'b1, 32'h400, 2'd2, 4'd6, 1'b0, 1'b1, 32'h0};
        fwd_table[11] = '{1'b1, 32'h502, 2'd1, 4'd6, 1'b1, 1'b0, 32'h1234};
        fwd_table[12] = '{1'b1, 32'h500, 2'd2, 4'd5, 1'b0, 1'b1, 32'h0};
        fwd_table[13] = '{1'b1, 32'h202, 2'd0, 4'd0, 1'b0, 1'b0, 32'h0};
        fwd_table[14] = '{1'b0, 32'h202, 2'd0, 4'd2, 1'b0, 1'b0, 32'h0};

        rst = 1'b1; disp_data = '0; exec_idx = '0; exec_addr = '0; exec_size = '0;
        cmit_idx = '0; ld_addr = '0; ld_size = '0; ld_marker = '0;
        do_reset();
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_issue_vld", 32'(issue_vld), 32'd0);
        checkOutput("rst_alloc_ptr", 32'(alloc_ptr), 32'd0);
        checkOutput("rst_ld_hit", 32'(ld_hit), 32'd0);
        checkOutput("rst_ld_stall", 32'(ld_stall), 32'd0);
        checkOutput("rst_ld_data", ld_data, 32'd0);

        $display("[TB] fill to full, drop extra dispatch, reset mid-operation");
        for (int i = 0; i < 7; i++) dispatch(32'h100 + 32'(i));
        #1;
        checkOutput("fill7_full", 32'(full), 32'd0);
        checkOutput("fill7_alloc", 32'(alloc_ptr), 32'd7);
        dispatch(32'h107);
        #1;
        checkOutput("fill8_full", 32'(full), 32'd1);
        checkOutput("fill8_alloc", 32'(alloc_ptr), 32'd8);
        dispatch(32'h999);
        #1;
        checkOutput("drop_full", 32'(full), 32'd1);
        checkOutput("drop_alloc", 32'(alloc_ptr), 32'd8);
        exec_vld = 1'b1; exec_idx = 3'd0; exec_addr = 32'h10; exec_size = 2'd2;
        cmit_vld = 1'b1; cmit_idx = 3'd0;
        applyStimulus();
        #1;
        checkOutput("pre_rst_issue_vld", 32'(issue_vld), 32'd1);
        issue_rdy = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        issue_rdy = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_issue_vld", 32'(issue_vld), 32'd0);
        checkOutput("midrst_alloc", 32'(alloc_ptr), 32'd0);
        checkOutput("midrst_full", 32'(full), 32'd0);

        $display("[TB] issue backpressure");
        dispatch(32'hAABBCCDD);
        exec_vld = 1'b1; exec_idx = 3'd0; exec_addr = 32'h100; exec_size = 2'd2;
        commit_store(3'd0, 32'h100, 32'hAABBCCDD, 2'd2);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("hold%0d_vld", c), 32'(issue_vld), 32'd1);
            checkOutput($sformatf("hold%0d_addr", c), issue_addr, 32'h100);
            checkOutput($sformatf("hold%0d_data", c), issue_data, 32'hAABBCCDD);
            checkOutput($sformatf("hold%0d_size", c), 32'(issue_size), 32'd2);
            @(posedge clk);
        end
        #1;
        issue_rdy = 1'b1;
        @(posedge clk);
        #1;
        issue_rdy = 1'b0;
        #1;
        checkOutput("after_issue_vld", 32'(issue_vld), 32'd0);
        checkOutput("after_issue_alloc", 32'(alloc_ptr), 32'd1);
        checkOutput("after_issue_sb", 32'(sb.size()), 32'd0);
        check_load("empty_ld", 1'b1, 32'h100, 2'd2, 4'd1, 1'b0, 1'b0, 32'h0);

        $display("[TB] forwarding table");
        do_reset();
        dispatch(32'h11111111);
        dispatch(32'h22222222);
        dispatch(32'h0000005A);
        dispatch(32'hDEADBEEF);
        dispatch(32'h0000BEEF);
        dispatch(32'h12345678);
        exec_store(3'd0, 32'h200, 2'd2);
        exec_store(3'd1, 32'h200, 2'd2);
        exec_store(3'd2, 32'h301, 2'd0);
        exec_store(3'd4, 32'h402, 2'd1);
        exec_store(3'd5, 32'h500, 2'd2);
        #1;
        checkOutput("fwd_alloc", 32'(alloc_ptr), 32'd6);
        for (int i = 0; i < 15; i++) begin
            check_load($sformatf("fwd%0d", i), fwd_table[i].vld, fwd_table[i].addr, fwd_table[i].size,
                       fwd_table[i].marker, fwd_table[i].hit, fwd_table[i].stall, fwd_table[i].data);
        end

        $display("[TB] flush with same-cycle commit");
        do_reset();
        for (int i = 0; i < 5; i++) dispatch(32'h5000 + 32'(i));
        for (int i = 0; i < 5; i++) exec_store(3'(i), 32'h700 + 32'(4 * i), 2'd2);
        commit_store(3'd0, 32'h700, 32'h5000, 2'd2);
        commit_store(3'd1, 32'h704, 32'h5001, 2'd2);
        flush = 1'b1;
        commit_store(3'd2, 32'h708, 32'h5002, 2'd2);
        #1;
        checkOutput("flush_alloc", 32'(alloc_ptr), 32'd3);
        checkOutput("flush_full", 32'(full), 32'd0);
        checkOutput("flush_issue_vld", 32'(issue_vld), 32'd1);
        check_load("flush_sq3", 1'b1, 32'h70C, 2'd2, 4'd5, 1'b0, 1'b0, 32'h0);
        check_load("flush_sq4", 1'b1, 32'h710, 2'd2, 4'd5, 1'b0, 1'b0, 32'h0);
        check_load("flush_kept2", 1'b1, 32'h708, 2'd2, 4'd5, 1'b1, 1'b0, 32'h5002);
        dispatch(32'h6003);
        #1;
        checkOutput("flush_redisp_alloc", 32'(alloc_ptr), 32'd4);
        exec_store(3'd3, 32'h710, 2'd2);
        check_load("flush_new3", 1'b1, 32'h710, 2'd2, 4'd4, 1'b1, 1'b0, 32'h6003);
        commit_store(3'd3, 32'h710, 32'h6003, 2'd2);
        drain("flush_drain");
        checkOutput("flush_end_vld", 32'(issue_vld), 32'd0);
        checkOutput("flush_end_alloc", 32'(alloc_ptr), 32'd4);

        $display("[TB] wrap-around ordering");
        do_reset();
        issue_rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            dispatch(32'hC000 + 32'(i));
            exec_vld = 1'b1; exec_idx = 3'(i); exec_addr = 32'h900 + 32'(4 * i); exec_size = 2'd2;
            commit_store(3'(i), 32'h900 + 32'(4 * i), 32'hC000 + 32'(i), 2'd2);
        end
        drain("wrap_drain");
        checkOutput("wrap_head_alloc", 32'(alloc_ptr), 32'd7);
        checkOutput("wrap_idle_vld", 32'(issue_vld), 32'd0);
        dispatch(32'h77000007);
        dispatch(32'h0000AB00);
        dispatch(32'h11000001);
        #1;
        checkOutput("wrap_alloc", 32'(alloc_ptr), 32'd10);
        exec_store(3'd7, 32'h800, 2'd2);
        exec_store(3'd0, 32'h800, 2'd2);
        exec_store(3'd1, 32'h800, 2'd2);
        check_load("wrap_m9", 1'b1, 32'h800, 2'd2, 4'd9, 1'b1, 1'b0, 32'h0000AB00);
        check_load("wrap_m9_byte", 1'b1, 32'h801, 2'd0, 4'd9, 1'b1, 1'b0, 32'hAB);
        check_load("wrap_m8", 1'b1, 32'h800, 2'd2, 4'd8, 1'b1, 1'b0, 32'h77000007);
        check_load("wrap_m10", 1'b1, 32'h800, 2'd2, 4'd10, 1'b1, 1'b0, 32'h11000001);
        check_load("wrap_m7", 1'b1, 32'h800, 2'd2, 4'd7, 1'b0, 1'b0, 32'h0);

        #1;
        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
